bitwise_sequencer: RTL and testbench

BITWISE_SEQUENCER -- requirements
Module: bitwise_sequencer

---
 rtl/bitwise_seq_pkg.sv | 15 +
 rtl/bitwise_sequencer_iter_counter.sv | 36 +++
 rtl/bitwise_sequencer.sv | 110 +++++++++++
 tb/tb_bitwise_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_seq_pkg.sv
// Shared types and defaults for the bitwise sequencer and its iteration counter.
package bitwise_seq_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNTW  = 4;

    typedef logic [2:0] op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitwise_sequencer_iter_counter.sv
// Remaining-iteration down-counter: loads a count, decrements per iteration,
// flags the final iteration and never wraps below zero.
module iter_counter #(
    parameter int unsigned CNTW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [CNTW-1:0] load_val_i,
    input  logic            dec_i,
    output logic            last_o
);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNTW'(1));

endmodule

// File: rtl/bitwise_sequencer.sv
// Iterates an external bitwise unit N times over a working a/carry pair,
// feeding each result back as the next operand; all bw_* drives are registered.
module bitwise_sequencer
    import bitwise_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNTW  = DEF_CNTW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  op_t              cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic [CNTW-1:0]  cmd_count,
    output op_t              bw_op,
    output logic [WIDTH-1:0] bw_a,
    output logic [WIDTH-1:0] bw_b,
    output logic             bw_cin,
    input  logic [WIDTH-1:0] bw_q,
    input  logic             bw_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_q,
    output logic             res_cout
);

    state_t           state_q;
    op_t              op_q;
    logic [WIDTH-1:0] wa_q;
    logic [WIDTH-1:0] b_q;
    logic             wc_q;
    logic             last_iter;
    logic             accept;

    assign accept = (state_q == IDLE) && start;

    iter_counter #(
        .CNTW (CNTW)
    ) u_iter_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (cmd_count),
        .dec_i      (state_q == RUN),
        .last_o     (last_iter)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            wa_q     <= '0;
            b_q      <= '0;
            wc_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_q    <= '0;
            res_cout <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q <= cmd_op;
                        b_q  <= cmd_b;
                        wa_q <= cmd_a;
                        wc_q <= cmd_cin;
                        busy <= 1'b1;
                        // A zero-length command completes straight from the latched operands.
                        if (cmd_count == '0) begin
                            state_q  <= DONE;
                            done     <= 1'b1;
                            res_q    <= cmd_a;
                            res_cout <= cmd_cin;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    wa_q <= bw_q;
                    wc_q <= bw_cout;
                    if (last_iter) begin
                        state_q  <= DONE;
                        done     <= 1'b1;
                        res_q    <= bw_q;
                        res_cout <= bw_cout;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bw_op  = op_q;
    assign bw_b   = b_q;
    assign bw_a   = wa_q;
    assign bw_cin = wc_q;

endmodule

// File: tb/tb_bitwise_sequencer.sv
// Directed bench for bitwise_sequencer with a rotate-through-carry stub and a
// result scoreboard filled at command issue and drained at each done pulse.
module tb_bitwise_sequencer;

    localparam int unsigned W = 8;
    localparam int unsigned C = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_cin;
    logic [C-1:0] cmd_count;
    logic [2:0]   bw_op;
    logic [W-1:0] bw_a;
    logic [W-1:0] bw_b;
    logic         bw_cin;
    logic [W-1:0] bw_q;
    logic         bw_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] res_q;
    logic         res_cout;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [W-1:0] q;
        logic         c;
        int unsigned  lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] alog [0:15];

    bitwise_sequencer #(
        .WIDTH (W),
        .CNTW  (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_cin   (cmd_cin),
        .cmd_count (cmd_count),
        .bw_op     (bw_op),
        .bw_a      (bw_a),
        .bw_b      (bw_b),
        .bw_cin    (bw_cin),
        .bw_q      (bw_q),
        .bw_cout   (bw_cout),
        .busy      (busy),
        .done      (done),
        .res_q     (res_q),
        .res_cout  (res_cout)
    );

    always #5 clk = ~clk;

    assign bw_q    = {bw_a[W-2:0], bw_cin};
    assign bw_cout = bw_a[W-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Rotates the 9-bit ring {a, carry} left n times.
    function automatic exp_t model(input logic [W-1:0] a, input logic cin, input int unsigned n);
        logic [W:0] r;
        exp_t       e;
        r = {a, cin};
        for (int unsigned i = 0; i < n; i++) r = {r[W-1:0], r[W]};
        e.q   = r[W:1];
        e.c   = r[0];
        e.lat = n + 1;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic cin, input logic [C-1:0] n,
                         input logic [W-1:0] b, input logic [2:0] op, input bit push);
        @(negedge clk);
        start = 1'b1; cmd_a = a; cmd_cin = cin; cmd_count = n; cmd_b = b; cmd_op = op;
        if (push) sb.push_back(model(a, cin, int'(n)));
        @(posedge clk);
        #1;
        start = 1'b0; cmd_a = ~a; cmd_cin = ~cin; cmd_b = ~b; cmd_op = ~op; cmd_count = '1;
        chk("latched_b", 32'(bw_b), 32'(b));
        chk("latched_op", 32'(bw_op), 32'(op));
        chk("latched_cin", 32'(bw_cin), 32'(cin));
    endtask

    task automatic collect(input string tag);
        int unsigned cyc;
        exp_t        e;
        cyc     = 1;
        alog[0] = bw_a;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            if (cyc < 16) alog[cyc] = bw_a;
            cyc++;
        end
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, ".latency"}, cyc, e.lat);
            chk({tag, ".res_q"}, 32'(res_q), 32'(e.q));
            chk({tag, ".res_cout"}, 32'(res_cout), 32'(e.c));
            chk({tag, ".busy_done"}, 32'(busy), 32'(1));
            @(posedge clk);
            #1;
            chk({tag, ".done_1cyc"}, 32'(done), 32'(0));
            chk({tag, ".idle_busy"}, 32'(busy), 32'(0));
            chk({tag, ".res_hold"}, 32'({res_cout, res_q}), 32'({e.c, e.q}));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_cin = 1'b0; cmd_count = '0;
        #2;
        chk("rst.busy", 32'(busy), 32'(0));
        chk("rst.done", 32'(done), 32'(0));
        chk("rst.res", 32'({res_cout, res_q}), 32'(0));
        chk("rst.bw", 32'({bw_op, bw_b, bw_a, bw_cin}), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        issue(8'h81, 1'b0, 4'd1, 8'h33, 3'd5, 1'b1);
        collect("c1");
        chk("c1.const", 32'({res_cout, res_q}), 32'({1'b1, 8'h02}));

        issue(8'hA5, 1'b1, 4'd4, 8'hC6, 3'd2, 1'b1);
        collect("c4");
        chk("c4.const", 32'({res_cout, res_q}), 32'({1'b0, 8'h5D}));
        chk("c4.bw_a0", 32'(alog[0]), 32'(8'hA5));
        chk("c4.bw_a1", 32'(alog[1]), 32'(8'h4B));
        chk("c4.bw_a2", 32'(alog[2]), 32'(8'h97));
        chk("c4.bw_a3", 32'(alog[3]), 32'(8'h2E));

        issue(8'h81, 1'b0, 4'd9, 8'h00, 3'd7, 1'b1);
        collect("c9");
        chk("c9.const", 32'({res_cout, res_q}), 32'({1'b0, 8'h81}));

        issue(8'h3C, 1'b1, 4'd0, 8'h5A, 3'd1, 1'b1);
        collect("c0");
        chk("c0.const", 32'({res_cout, res_q}), 32'({1'b1, 8'h3C}));

        issue(8'h5A, 1'b0, 4'd15, 8'hFF, 3'd3, 1'b1);
        collect("c15");

        // start held high: one completion, then re-accept in the first IDLE cycle
        @(negedge clk);
        start = 1'b1; cmd_a = 8'h81; cmd_cin = 1'b0; cmd_count = 4'd3; cmd_b = 8'h11; cmd_op = 3'd4;
        sb.push_back(model(8'h81, 1'b0, 3));
        @(posedge clk);
        #1;
        collect("hold1");
        @(posedge clk);
        #1;
        chk("hold.reaccept", 32'(busy), 32'(1));
        chk("hold.no_done", 32'(done), 32'(0));
        start = 1'b0;
        sb.push_back(model(8'h81, 1'b0, 3));
        collect("hold2");

        // reset in the second RUN cycle aborts the command
        issue(8'hC3, 1'b1, 4'd5, 8'h22, 3'd6, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort.busy", 32'(busy), 32'(0));
        chk("abort.done", 32'(done), 32'(0));
        chk("abort.res", 32'({res_cout, res_q}), 32'(0));
        chk("abort.bw_a", 32'({bw_a, bw_cin}), 32'(0));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("abort.quiet", 32'({done, busy}), 32'(0));
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b1; cmd_a = 8'h0F; cmd_cin = 1'b1; cmd_count = 4'd2;
        cmd_b = 8'h44; cmd_op = 3'd1;
        sb.push_back(model(8'h0F, 1'b1, 2));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("post_rst.accept", 32'(busy), 32'(1));
        collect("post_rst");

        chk("sb.drained", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
